// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, funct fields, ALU operation classes and
// the 4-bit ALU control codes used between decode and execute.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [3:0] ALUCTL_AND = 4'b0000;
  localparam logic [3:0] ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTL_SLT = 4'b0111;
  localparam logic [3:0] ALUCTL_NOR = 4'b1100;

endpackage

// File: rtl/mips_ctrl_exec_unit_if.sv
// Decode/execute signal bundle: master drives instruction fields and ALU
// operands, slave returns control decode and ALU results.
interface mips_ctrl_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [5:0]       opcode;
  logic [5:0]       func;
  logic             regdst;
  logic             branch_eq;
  logic             branch_ne;
  logic             memread;
  logic             memwrite;
  logic             memtoreg;
  logic [1:0]       aluop;
  logic             regwrite;
  logic             alusrc;
  logic             jump;
  logic [1:0]       ex_aluop;
  logic [5:0]       ex_funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       aluctl;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic [WIDTH-1:0] alu_out_q;
  logic             zero_q;

  modport master (
    output opcode, func, ex_aluop, ex_funct, a, b,
    input  regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
           aluop, regwrite, alusrc, jump, aluctl, alu_out, zero,
           alu_out_q, zero_q
  );

  modport slave (
    input  opcode, func, ex_aluop, ex_funct, a, b,
    output regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
           aluop, regwrite, alusrc, jump, aluctl, alu_out, zero,
           alu_out_q, zero_q
  );
endinterface

// File: rtl/mips_alu32.sv
// Combinational ALU with zero flag; unknown control codes yield 0.
module mips_alu32
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       aluctl_i,
  output logic [WIDTH-1:0] alu_out_o,
  output logic             zero_o
);

  always_comb begin
    alu_out_o = '0;
    case (aluctl_i)
      ALUCTL_AND: alu_out_o = a_i & b_i;
      ALUCTL_OR:  alu_out_o = a_i | b_i;
      ALUCTL_ADD: alu_out_o = a_i + b_i;
      ALUCTL_SUB: alu_out_o = a_i - b_i;
      ALUCTL_SLT: alu_out_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALUCTL_NOR: alu_out_o = ~(a_i | b_i);
      default:    alu_out_o = '0;
    endcase
  end

  assign zero_o = (alu_out_o == '0);

endmodule

// File: rtl/mips_ctrl_exec_unit.sv
// ID-stage main control decoder, EX-stage ALU control decoder, ALU and the
// EX/MEM copy of the ALU result and zero flag.
module mips_ctrl_exec_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_ctrl_exec_unit_if.slave bus
);

  logic [WIDTH-1:0] alu_out_d;
  logic [WIDTH-1:0] alu_out_q;
  logic             zero_d;
  logic             zero_q;

  // An all-zero word is a NOP, so R-type only when func is nonzero.
  always_comb begin
    bus.regdst    = 1'b0;
    bus.branch_eq = 1'b0;
    bus.branch_ne = 1'b0;
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.memtoreg  = 1'b0;
    bus.aluop     = ALUOP_ADD;
    bus.regwrite  = 1'b0;
    bus.alusrc    = 1'b0;
    bus.jump      = 1'b0;
    case (bus.opcode)
      OP_RTYPE: begin
        if (bus.func != 6'b000000) begin
          bus.regdst   = 1'b1;
          bus.regwrite = 1'b1;
          bus.aluop    = ALUOP_FUNC;
        end
      end
      OP_LW: begin
        bus.memread  = 1'b1;
        bus.memtoreg = 1'b1;
        bus.alusrc   = 1'b1;
        bus.regwrite = 1'b1;
      end
      OP_SW: begin
        bus.memwrite = 1'b1;
        bus.alusrc   = 1'b1;
      end
      OP_ADDI: begin
        bus.alusrc   = 1'b1;
        bus.regwrite = 1'b1;
      end
      OP_BEQ: begin
        bus.branch_eq = 1'b1;
        bus.aluop     = ALUOP_SUB;
      end
      OP_BNE: begin
        bus.branch_ne = 1'b1;
        bus.aluop     = ALUOP_SUB;
      end
      OP_J:    bus.jump = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    bus.aluctl = ALUCTL_ADD;
    case (bus.ex_aluop)
      ALUOP_SUB:  bus.aluctl = ALUCTL_SUB;
      ALUOP_FUNC: begin
        case (bus.ex_funct)
          F_ADD:   bus.aluctl = ALUCTL_ADD;
          F_SUB:   bus.aluctl = ALUCTL_SUB;
          F_AND:   bus.aluctl = ALUCTL_AND;
          F_OR:    bus.aluctl = ALUCTL_OR;
          F_NOR:   bus.aluctl = ALUCTL_NOR;
          F_SLT:   bus.aluctl = ALUCTL_SLT;
          default: bus.aluctl = ALUCTL_ADD;
        endcase
      end
      default: bus.aluctl = ALUCTL_ADD;
    endcase
  end

  mips_alu32 #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a_i       (bus.a),
    .b_i       (bus.b),
    .aluctl_i  (bus.aluctl),
    .alu_out_o (alu_out_d),
    .zero_o    (zero_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.alu_out   = alu_out_d;
  assign bus.zero      = zero_d;
  assign bus.alu_out_q = alu_out_q;
  assign bus.zero_q    = zero_q;

endmodule

// File: tb/tb_mips_ctrl_exec_unit.sv
// Directed bench for mips_ctrl_exec_unit: literal checks from hand-worked
// vectors plus a per-cycle comparison against a behavioural model.
module tb_mips_ctrl_exec_unit;

  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  mips_ctrl_exec_unit_if #(.WIDTH(W)) bus ();

  mips_ctrl_exec_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, aluop[1:0], regwrite, alusrc, jump}
  logic [10:0] ctrl_act;
  assign ctrl_act = {bus.regdst, bus.branch_eq, bus.branch_ne, bus.memread,
                     bus.memwrite, bus.memtoreg, bus.aluop, bus.regwrite,
                     bus.alusrc, bus.jump};

  function automatic logic [10:0] mdl_ctrl(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b0) ? 11'b0 : 11'b100_000_10_100;
      6'b100011: return 11'b000_101_00_110;
      6'b101011: return 11'b000_010_00_010;
      6'b001000: return 11'b000_000_00_110;
      6'b000100: return 11'b010_000_01_000;
      6'b000101: return 11'b001_000_01_000;
      6'b000010: return 11'b000_000_00_001;
      default:   return 11'b0;
    endcase
  endfunction

  function automatic logic [3:0] mdl_aluctl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b01) return 4'b0110;
    if (op != 2'b10) return 4'b0010;
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic logic [31:0] mdl_alu(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (mdl_aluctl(op, fn))
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return 32'((64'(x) + 64'(y)) % 64'h1_0000_0000);
      4'b0110: return 32'((64'h1_0000_0000 + 64'(x) - 64'(y)) % 64'h1_0000_0000);
      4'b0111: return (sx < sy) ? 32'd1 : 32'd0;
      4'b1100: return ~(x | y);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [31:0] exp_q  = '0;
  logic        exp_zq = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q  = '0;
      exp_zq = 1'b0;
    end else begin
      exp_q  = mdl_alu(bus.ex_aluop, bus.ex_funct, bus.a, bus.b);
      exp_zq = (exp_q == 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [31:0] r;
    r = mdl_alu(bus.ex_aluop, bus.ex_funct, bus.a, bus.b);
    chk("model_ctrl",      32'(ctrl_act), 32'(mdl_ctrl(bus.opcode, bus.func)));
    chk("model_aluctl",    32'(bus.aluctl), 32'(mdl_aluctl(bus.ex_aluop, bus.ex_funct)));
    chk("model_alu_out",   bus.alu_out, r);
    chk("model_zero",      32'(bus.zero), 32'(r == 32'd0));
    chk("model_alu_out_q", bus.alu_out_q, exp_q);
    chk("model_zero_q",    32'(bus.zero_q), 32'(exp_zq));
  end

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] exop,
                      input logic [5:0] exfn, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk);
    #1;
    bus.opcode   = op;
    bus.func     = fn;
    bus.ex_aluop = exop;
    bus.ex_funct = exfn;
    bus.a        = x;
    bus.b        = y;
    #1;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [1:0]  exop;
    logic [5:0]  exfn;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t tbl[8];

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    bus.opcode = '0; bus.func = '0; bus.ex_aluop = '0; bus.ex_funct = '0;
    bus.a = '0; bus.b = '0;
    #2;
    chk("reset_alu_out_q", bus.alu_out_q, 32'd0);
    chk("reset_zero_q",    32'(bus.zero_q), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    step(6'b100011, 6'b000000, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    chk("lw_ctrl",    32'(ctrl_act), 32'(11'b000_101_00_110));
    chk("slt_aluctl", 32'(bus.aluctl), 32'h7);
    chk("slt_out",    bus.alu_out, 32'd1);
    chk("slt_zero",   32'(bus.zero), 32'd0);

    step(6'b000000, 6'b000000, 2'b10, 6'b100111, 32'd0, 32'd0);
    chk("slt_out_q",  bus.alu_out_q, 32'd1);
    chk("nop_ctrl",   32'(ctrl_act), 32'd0);
    chk("nor_out",    bus.alu_out, 32'hFFFF_FFFF);

    step(6'b000000, 6'b100010, 2'b01, 6'b000000, 32'd5, 32'd5);
    chk("rtype_ctrl", 32'(ctrl_act), 32'(11'b100_000_10_100));
    chk("sub_out",    bus.alu_out, 32'd0);
    chk("sub_zero",   32'(bus.zero), 32'd1);

    step(6'b000101, 6'b000000, 2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1);
    chk("sub_zero_q", 32'(bus.zero_q), 32'd1);
    chk("bne_ctrl",   32'(ctrl_act), 32'(11'b001_000_01_000));
    chk("wrap_out",   bus.alu_out, 32'd0);
    chk("wrap_zero",  32'(bus.zero), 32'd1);

    step(6'b000010, 6'b000000, 2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00);
    chk("j_ctrl",     32'(ctrl_act), 32'(11'b000_000_00_001));
    chk("and_out",    bus.alu_out, 32'h00F0_1200);

    tbl[0] = '{6'b101011, 6'b000000, 2'b10, 6'b100101, 32'hA000_0001, 32'h0500_0010};
    tbl[1] = '{6'b001000, 6'b000000, 2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1};
    tbl[2] = '{6'b000100, 6'b000000, 2'b10, 6'b111111, 32'd3, 32'd4};
    tbl[3] = '{6'b001100, 6'b000000, 2'b11, 6'b100010, 32'd9, 32'd2};
    tbl[4] = '{6'b000000, 6'b100000, 2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFE};
    tbl[5] = '{6'b111111, 6'b111111, 2'b10, 6'b101010, 32'h8000_0000, 32'h7FFF_FFFF};
    tbl[6] = '{6'b000000, 6'b000001, 2'b01, 6'b000000, 32'd0, 32'd1};
    tbl[7] = '{6'b100011, 6'b101010, 2'b10, 6'b100111, 32'h0000_FFFF, 32'hFFFF_0000};
    for (int i = 0; i < 8; i++)
      step(tbl[i].op, tbl[i].fn, tbl[i].exop, tbl[i].exfn, tbl[i].x, tbl[i].y);

    step(6'b000000, 6'b000000, 2'b00, 6'b000000, 32'd7, 32'd0);
    @(posedge clk); #1;
    chk("preload_q", bus.alu_out_q, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("async_rst_q",      bus.alu_out_q, 32'd0);
    chk("async_rst_zero_q", 32'(bus.zero_q), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(6'b000000, 6'b000000, 2'b00, 6'b000000, 32'd3, 32'd4);
    @(posedge clk); #1;
    chk("post_rst_q", bus.alu_out_q, 32'd7);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips_ctrl_exec_unit.md
Name: mips_ctrl_exec_unit

Overview:
- Combined decode/execute datapath slice for the 5-stage MIPS pipeline.
- Holds the ID-stage main control decoder, which treats an all-zero instruction as a NOP and emits all control signals as 0.
- Holds the EX-stage ALU-control decoder and the 32-bit ALU.
- The ALU result and zero flag are presented combinationally and also as a registered EX/MEM copy.

Parameters:
- WIDTH, 32, datapath width of the ALU operands and result.

Ports:
- clk  in  1  pipeline clock; all registers update on the rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  ID-stage instruction bits [31:26]
- func  in  6  ID-stage instruction bits [5:0]
- regdst  out  1  write-register select: 1 selects rd, 0 selects rt
- branch_eq  out  1  instruction is beq
- branch_ne  out  1  instruction is bne
- memread  out  1  data-memory read
- memwrite  out  1  data-memory write
- memtoreg  out  1  writeback selects memory data
- aluop  out  2  ALU operation class passed down the pipeline
- regwrite  out  1  register-file write enable
- alusrc  out  1  ALU B operand selects the immediate
- jump  out  1  instruction is j
- ex_aluop  in  2  EX-stage aluop
- ex_funct  in  6  EX-stage funct, taken from seimm[5:0]
- a  in  WIDTH  ALU operand A, already forwarded
- b  in  WIDTH  ALU operand B, after the alusrc mux
- aluctl  out  4  decoded ALU control
- alu_out  out  WIDTH  combinational ALU result
- zero  out  1  combinational flag, high when alu_out == 0
- alu_out_q  out  WIDTH  registered alu_out
- zero_q  out  1  registered zero

Behaviour:
- Main decoder (combinational). Every signal defaults to 0; an unlisted opcode yields all 0.
  - opcode 000000, func != 000000 (R-type): regdst=1, regwrite=1, aluop=10.
  - opcode 000000, func == 000000 (NOP, and likewise an all-zero word): all outputs 0, so no register write.
  - opcode 100011 (lw): memread=1, memtoreg=1, alusrc=1, regwrite=1, aluop=00.
  - opcode 101011 (sw): memwrite=1, alusrc=1, aluop=00.
  - opcode 001000 (addi): alusrc=1, regwrite=1, aluop=00.
  - opcode 000100 (beq): branch_eq=1, aluop=01.
  - opcode 000101 (bne): branch_ne=1, aluop=01.
  - opcode 000010 (j): jump=1.
- ALU control (combinational).
  - ex_aluop 00 gives 0010 (add); 01 gives 0110 (sub); 11 gives 0010.
  - ex_aluop 10 decodes ex_funct: 100000 gives 0010 (add), 100010 gives 0110 (sub), 100100 gives 0000 (and), 100101 gives 0001 (or), 100111 gives 1100 (nor), 101010 gives 0111 (slt).
  - Any other ex_funct under aluop 10 gives 0010.
- ALU (combinational).
  - 0000: a & b.
  - 0001: a | b.
  - 0010: a + b, modulo 2^WIDTH, overflow ignored.
  - 0110: a - b, modulo 2^WIDTH.
  - 0111: 1 if signed(a) < signed(b), else 0.
  - 1100: ~(a | b).
  - Any other code: 0.
  - zero = (alu_out == 0).
- Registers:
  - alu_out_q and zero_q capture alu_out and zero on every rising clk edge; latency is 1 cycle; there is no enable.
  - rst_n low asynchronously clears alu_out_q to 0 and zero_q to 0. Reset asserted mid-operation overrides any capture.
  - The first edge after rst_n deasserts captures normally.
- Decoder outputs are purely combinational and unaffected by reset.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J;
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT;
  - aluop constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10;
  - 4-bit ALUCTL_* codes.
- One natural sub-module, mips_alu32: the combinational ALU plus zero flag.
- The two decoders stay inline.

Test Plan:
- opcode=100011 → memread=memtoreg=alusrc=regwrite=1, aluop=00, all other outputs 0.
- opcode=000000, func=000000 → all control outputs 0.
- opcode=000000, func=100010 → regdst=regwrite=1, aluop=10.
- opcode=000101 → branch_ne=1, aluop=01.
- opcode=000010 → jump=1.
- ex_aluop=10, ex_funct=101010, a=32'hFFFFFFFF, b=1 → aluctl=0111, alu_out=1, zero=0. At the next edge alu_out_q=1.
- ex_aluop=10, ex_funct=100111, a=0, b=0 → alu_out=32'hFFFFFFFF.
- ex_aluop=01, a=b=32'd5 → alu_out=0, zero=1, zero_q=1 after the edge.
- ex_aluop=00, a=32'hFFFFFFFF, b=1 → alu_out=0, zero=1 (wrap-around).
- Load alu_out_q with a nonzero value, then drop rst_n between clock edges → alu_out_q and zero_q become 0 immediately, without waiting for clk.
